fft_frame_scheduler: RTL and testbench

- Single-clock controller that sequences FFT output samples into the output FIFO, one frame at a time.
- Armed by a host pulse. Discards the FFT pipeline warm-up samples once per arm, then writes framed data: one header word followed by N_POINTS samples packed as {re, im}.
- Checks FIFO room before each frame and drops whole frames rather than truncating them.
- Sits between the FFT core output and the write side of the dual-clock output FIFO.

---
 rtl/fft_frame_scheduler_pkg.sv | 21 ++
 rtl/fft_frame_scheduler_sat_cnt.sv | 20 ++
 rtl/fft_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and helpers for the FFT frame scheduler: state encoding, header layout, FIFO word width.
package fft_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_START,
        ST_STREAM,
        ST_FLUSH,
        ST_DROP
    } state_t;

    localparam int          FIFO_W      = 32;
    localparam logic [15:0] SYNC_HI_DEF = 16'hA55A;

    function automatic logic [FIFO_W-1:0] pack_hdr(input logic [15:0] sync_hi,
                                                   input logic [15:0] frame_no);
        return {sync_hi, frame_no};
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_sat_cnt.sv
// Saturating up-counter; value updates the cycle after inc, holds at all-ones.
// No backpressure: inc is sampled every cycle.
module fft_frame_scheduler_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frames FFT output into the output FIFO: header then N_POINTS {re,im} words, whole-frame drop when short of room.
// Output lags accepted samples by one valid sample; FIFO room is checked once per frame, fifo_full only suppresses writes.
module fft_frame_scheduler
    import fft_frame_scheduler_pkg::*;
#(
    parameter int          N_POINTS   = 1024,
    parameter int          LATENCY    = 1025,
    parameter int          FIFO_DEPTH = 4096,
    parameter logic [15:0] SYNC_HI    = SYNC_HI_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              arm,
    input  logic              continuous,
    input  logic              fft_valid,
    input  logic [15:0]       data_in_re,
    input  logic [15:0]       data_in_im,
    input  logic              fifo_full,
    input  logic [12:0]       fifo_wr_count,
    output logic [FIFO_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);

    localparam int             MAX_CNT  = (N_POINTS > LATENCY) ? N_POINTS : LATENCY;
    localparam int             CW       = $clog2(MAX_CNT) + 1;
    localparam logic [13:0]    DEPTH14  = 14'(FIFO_DEPTH);
    localparam logic [13:0]    NEED14   = 14'(N_POINTS + 1);
    localparam logic [CW-1:0]  LAT_LAST = CW'(LATENCY - 1);
    localparam logic [CW-1:0]  N_LAST   = CW'(N_POINTS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [FIFO_W-1:0] hold;
    logic [FIFO_W-1:0] sample;
    logic [13:0]       room;
    logic              fits;
    logic              drop_inc;

    assign sample   = {data_in_re, data_in_im};
    assign room     = DEPTH14 - {1'b0, fifo_wr_count};
    assign fits     = (room >= NEED14);
    assign drop_inc = (state == ST_DROP) && fft_valid && (cnt == N_LAST);

    // cnt doubles as warm-up counter (WARMUP) and in-frame sample counter (START..DROP).
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold       <= '0;
            fifo_din   <= '0;
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state <= ST_WARMUP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (fft_valid) begin
                        if (cnt == LAT_LAST) begin
                            state <= ST_START;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (fft_valid) begin
                        cnt <= CW'(1);
                        if (fits) begin
                            fifo_din   <= pack_hdr(SYNC_HI, frame_cnt);
                            fifo_wr_en <= ~fifo_full;
                            overflow   <= overflow | fifo_full;
                            hold       <= sample;
                            state      <= ST_STREAM;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_STREAM: begin
                    if (fft_valid) begin
                        fifo_din   <= hold;
                        fifo_wr_en <= ~fifo_full;
                        overflow   <= overflow | fifo_full;
                        hold       <= sample;
                        cnt        <= cnt + 1'b1;
                        if (cnt == N_LAST) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    fifo_din   <= hold;
                    fifo_wr_en <= ~fifo_full;
                    overflow   <= overflow | fifo_full;
                    frame_cnt  <= frame_cnt + 16'd1;
                    frame_done <= 1'b1;
                    state      <= continuous ? ST_START : ST_IDLE;
                    busy       <= continuous;
                end
                ST_DROP: begin
                    if (fft_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == N_LAST) begin
                            frame_done <= 1'b1;
                            state      <= continuous ? ST_START : ST_IDLE;
                            busy       <= continuous;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    fft_frame_scheduler_sat_cnt #(
        .W(16)
    ) u_drop_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .inc   (drop_inc),
        .value (drop_cnt)
    );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: table of frame scenarios plus hand-written drop, overflow and reset sequences.
module tb_fft_frame_scheduler;

    localparam int N = 1024;
    localparam int L = 1025;

    logic        CLK = 1'b0;
    logic        reset, arm, continuous, fft_valid, fifo_full;
    logic [15:0] data_in_re, data_in_im;
    logic [12:0] fifo_wr_count;
    logic [31:0] fifo_din;
    logic        fifo_wr_en, busy, frame_done, overflow;
    logic [15:0] frame_cnt, drop_cnt;

    always #5 CLK = ~CLK;

    fft_frame_scheduler #(
        .N_POINTS(N), .LATENCY(L), .FIFO_DEPTH(4096), .SYNC_HI(16'hA55A)
    ) dut (
        .CLK(CLK), .reset(reset), .arm(arm), .continuous(continuous),
        .fft_valid(fft_valid), .data_in_re(data_in_re), .data_in_im(data_in_im),
        .fifo_full(fifo_full), .fifo_wr_count(fifo_wr_count),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    typedef struct {
        logic cont;
        int   nframes;
        logic gappy;
        int   exp_words;
        int   exp_frames;
        int   exp_drops;
        int   exp_done;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          idx = 0;
    logic [31:0] cap[$];
    logic [31:0] exp_q[$];

    // FIFO-side capture, sampled on the falling edge away from register updates.
    always @(negedge CLK) begin
        if (fifo_wr_en) cap.push_back(fifo_din);
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] sw(input int k);
        logic [15:0] r;
        r = k[15:0];
        return {r, r ^ 16'h5A5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check_seq(input string name, input int base);
        int bad;
        int n;
        bad = -1;
        n = cap.size() - base;
        check({name, "_len"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (cap[base+i] !== exp_q[i] && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: word %0d got %08h expected %08h", name, bad, cap[base+bad], exp_q[bad]);
        end
    endtask

    task automatic drive(input logic v, input logic a);
        fft_valid  = v;
        arm        = a;
        data_in_re = idx[15:0];
        data_in_im = idx[15:0] ^ 16'h5A5A;
        @(posedge CLK);
        #1;
        if (v) idx++;
        fft_valid = 1'b0;
        arm       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; arm = 1'b0; continuous = 1'b0; fft_valid = 1'b0;
        fifo_full = 1'b0; fifo_wr_count = '0; data_in_re = '0; data_in_im = '0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (4) drive(1'b0, 1'b0);
        while (busy && n < 50) begin
            drive(1'b0, 1'b0);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[3];

    initial begin
        int base, dbase, b, total, drop_at, cyc;
        logic v;

        vecs[0] = '{cont: 1'b0, nframes: 1, gappy: 1'b0, exp_words: 1025, exp_frames: 1, exp_drops: 0, exp_done: 1};
        vecs[1] = '{cont: 1'b0, nframes: 1, gappy: 1'b1, exp_words: 1025, exp_frames: 1, exp_drops: 0, exp_done: 1};
        vecs[2] = '{cont: 1'b1, nframes: 3, gappy: 1'b0, exp_words: 3075, exp_frames: 3, exp_drops: 0, exp_done: 3};

        do_reset();
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_din", 64'(fifo_din), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        for (int t = 0; t < 3; t++) begin
            do_reset();
            base  = cap.size();
            dbase = done_cnt;
            continuous = vecs[t].cont;
            drive(1'b0, 1'b1);
            b = idx;
            // With valid held high, the sample arriving during FLUSH is not consumed by any frame.
            exp_q.delete();
            for (int k = 0; k < vecs[t].nframes; k++) begin
                exp_q.push_back({16'hA55A, 16'(k)});
                for (int j = 0; j < N; j++) exp_q.push_back(sw(b + L + k*(N+1) + j));
            end
            check($sformatf("v%0d_exp_words", t), 64'(exp_q.size()), 64'(vecs[t].exp_words));
            total   = L + vecs[t].nframes*(N+1) - 1;
            drop_at = L + (vecs[t].nframes-1)*(N+1) + 5;
            cyc = 0;
            while ((idx - b) < total && cyc < 40000) begin
                v = vecs[t].gappy ? 1'($urandom_range(0, 1)) : 1'b1;
                drive(v, (idx - b) == L + 300);
                if ((idx - b) >= drop_at) continuous = 1'b0;
                cyc++;
            end
            check($sformatf("v%0d_budget", t), 64'(cyc < 40000), 64'd1);
            wait_idle($sformatf("v%0d", t));
            check_seq($sformatf("v%0d_words", t), base);
            check($sformatf("v%0d_frame_cnt", t), 64'(frame_cnt), 64'(vecs[t].exp_frames));
            check($sformatf("v%0d_drop_cnt", t), 64'(drop_cnt), 64'(vecs[t].exp_drops));
            check($sformatf("v%0d_done", t), 64'(done_cnt - dbase), 64'(vecs[t].exp_done));
            check($sformatf("v%0d_overflow", t), 64'(overflow), 64'd0);
        end

        // Room 1024 drops the first frame; room 1025 (count 3071) exactly fits the second.
        do_reset();
        base  = cap.size();
        dbase = done_cnt;
        fifo_wr_count = 13'd3072;
        continuous = 1'b1;
        drive(1'b0, 1'b1);
        b = idx;
        repeat (L + N) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("drop_no_writes", 64'(cap.size() - base), 64'd0);
        check("drop_cnt_1", 64'(drop_cnt), 64'd1);
        check("drop_busy", 64'(busy), 64'd1);
        fifo_wr_count = 13'd3071;
        continuous = 1'b0;
        repeat (N) drive(1'b1, 1'b0);
        wait_idle("drop");
        exp_q.delete();
        exp_q.push_back(32'hA55A0000);
        for (int j = 0; j < N; j++) exp_q.push_back(sw(b + L + N + j));
        check_seq("drop_words", base);
        check("drop_frame_cnt", 64'(frame_cnt), 64'd1);
        check("drop_done", 64'(done_cnt - dbase), 64'd2);

        // fifo_full during five STREAM writes loses the held samples 199..203.
        do_reset();
        base  = cap.size();
        dbase = done_cnt;
        drive(1'b0, 1'b1);
        b = idx;
        repeat (L) drive(1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            fifo_full = (i >= 200 && i < 205);
            drive(1'b1, 1'b0);
        end
        fifo_full = 1'b0;
        wait_idle("ovf");
        exp_q.delete();
        exp_q.push_back(32'hA55A0000);
        for (int j = 0; j < N; j++)
            if (j < 199 || j > 203) exp_q.push_back(sw(b + L + j));
        check_seq("ovf_words", base);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_done", 64'(done_cnt - dbase), 64'd1);
        check("ovf_frame_cnt", 64'(frame_cnt), 64'd1);

        // Asynchronous reset mid-STREAM, then a fresh arm must warm up again.
        do_reset();
        drive(1'b0, 1'b1);
        repeat (L + 500) drive(1'b1, 1'b0);
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("arst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("arst_din", 64'(fifo_din), 64'd0);
        check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge CLK);
        #1 reset = 1'b1;
        base = cap.size();
        repeat (5) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("arst_idle_no_writes", 64'(cap.size() - base), 64'd0);
        base  = cap.size();
        dbase = done_cnt;
        drive(1'b0, 1'b1);
        b = idx;
        check("rearm_busy", 64'(busy), 64'd1);
        repeat (L + N) drive(1'b1, 1'b0);
        wait_idle("rearm");
        exp_q.delete();
        exp_q.push_back(32'hA55A0000);
        for (int j = 0; j < N; j++) exp_q.push_back(sw(b + L + j));
        check_seq("rearm_words", base);
        check("rearm_done", 64'(done_cnt - dbase), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
